adder_delay_pipe: RTL and testbench

- Parametrised, clocked successor to the behavioural delayed adder.
- Models a propagation delay as a fixed number of clock cycles instead of a `#` delay.
- Selectable TRANSPORT mode: every sampled operand set propagates to the outputs.
- Selectable INERTIAL mode: operand sets not held for LATENCY cycles are rejected and counted.
- Used as a synthesizable timing-accurate arithmetic stage in delay-modelling test structures.

---
 rtl/adder_delay_pipe.sv | 170 +++++++++++++++++
 tb/tb_adder_delay_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_delay_pipe.sv
// adder_delay_pipe: clocked adder whose result appears LATENCY cycles after
// the operands are sampled. MODE=0 passes every sample (transport delay);
// MODE=1 only passes operand sets held stable for LATENCY cycles (inertial
// delay) and counts the rejected ones.
module adder_delay_pipe #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 3,
    parameter int MODE    = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             glitch_drop,
    output logic [CNT_W-1:0] drop_count
);

    localparam int OPS_W = 2 * WIDTH + 1;

    // Operand bundle layout: {a, b, ci}
    function automatic logic [WIDTH:0] add_ops(input logic [OPS_W-1:0] ops);
        return {1'b0, ops[OPS_W-1:WIDTH+1]} + {1'b0, ops[WIDTH:1]} + {{WIDTH{1'b0}}, ops[0]};
    endfunction

    logic [OPS_W-1:0] w_ops;
    logic             w_commit_v;
    logic [WIDTH:0]   w_commit_res;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;

    assign w_ops = {a, b, ci};

    generate
        if (MODE == 0) begin : g_transport
            logic [WIDTH:0] w_full;
            assign w_full = add_ops(w_ops);

            if (LATENCY == 1) begin : g_direct
                assign w_commit_v   = in_valid;
                assign w_commit_res = w_full;
            end else begin : g_shift
                // The last stage of the delay line feeds the output register,
                // so the line is one entry shorter than LATENCY.
                logic           r_pv [LATENCY-1];
                logic [WIDTH:0] r_pd [LATENCY-1];

                // Shift {valid, co, sum} one stage per clock.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int k = 0; k < LATENCY - 1; k++) begin
                            r_pv[k] <= 1'b0;
                            r_pd[k] <= '0;
                        end
                    end else begin
                        r_pv[0] <= in_valid;
                        r_pd[0] <= w_full;
                        for (int k = 1; k < LATENCY - 1; k++) begin
                            r_pv[k] <= r_pv[k-1];
                            r_pd[k] <= r_pd[k-1];
                        end
                    end
                end

                assign w_commit_v   = r_pv[LATENCY-2];
                assign w_commit_res = r_pd[LATENCY-2];
            end

            assign glitch_drop = 1'b0;
            assign drop_count  = '0;
        end else begin : g_inertial
            localparam int AGE_W = $clog2(LATENCY + 1);
            localparam logic [AGE_W-1:0] AGE_LAT = AGE_W'(LATENCY);
            localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

            logic             r_pending;
            logic [OPS_W-1:0] r_cand;
            logic [AGE_W-1:0] r_age;
            logic             r_last_valid;
            logic [OPS_W-1:0] r_last;
            logic             r_glitch;
            logic [CNT_W-1:0] r_drop;

            logic             w_restart;
            logic             w_capture;
            logic             w_load;
            logic [OPS_W-1:0] w_cand_nxt;
            logic [AGE_W-1:0] w_age_nxt;

            // Decide restart/capture/commit for the coming edge. A restart
            // replaces the candidate, so an old candidate that would have
            // committed on the same edge is dropped instead. With LATENCY=1 a
            // freshly loaded candidate commits on its own load edge.
            always_comb begin
                w_restart    = 1'b0;
                w_capture    = 1'b0;
                w_load       = 1'b0;
                w_cand_nxt   = r_cand;
                w_age_nxt    = r_age + AGE_ONE;
                w_commit_v   = 1'b0;
                w_restart    = in_valid && r_pending && (w_ops != r_cand);
                w_capture    = in_valid && !r_pending && (!r_last_valid || (w_ops != r_last));
                w_load       = w_restart || w_capture;
                if (w_load) begin
                    w_cand_nxt = w_ops;
                    w_age_nxt  = AGE_ONE;
                end
                w_commit_v   = (w_load || r_pending) && (w_age_nxt == AGE_LAT);
                w_commit_res = add_ops(w_cand_nxt);
            end

            // Candidate, age and last-committed tracking plus drop reporting.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pending    <= 1'b0;
                    r_cand       <= '0;
                    r_age        <= '0;
                    r_last_valid <= 1'b0;
                    r_last       <= '0;
                    r_glitch     <= 1'b0;
                    r_drop       <= '0;
                end else begin
                    r_glitch <= w_restart;
                    if (w_restart && (r_drop != '1)) begin
                        r_drop <= r_drop + CNT_W'(1);
                    end
                    r_cand <= w_cand_nxt;
                    if (w_commit_v) begin
                        r_pending    <= 1'b0;
                        r_age        <= '0;
                        r_last_valid <= 1'b1;
                        r_last       <= w_cand_nxt;
                    end else if (w_load || r_pending) begin
                        r_pending <= 1'b1;
                        r_age     <= w_age_nxt;
                    end
                end
            end

            assign glitch_drop = r_glitch;
            assign drop_count  = r_drop;
        end
    endgenerate

    // Output register: pulse valid, hold the last committed sum otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_co        <= 1'b0;
        end else begin
            r_out_valid <= w_commit_v;
            if (w_commit_v) begin
                {r_co, r_sum} <= w_commit_res;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign co        = r_co;

endmodule

// File: tb/tb_adder_delay_pipe.sv
module tb_adder_delay_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       ci = 1'b0;

    logic       t_ov, t_co, t_gd;
    logic [3:0] t_sum;
    logic [7:0] t_dc;
    logic       i_ov, i_co, i_gd;
    logic [3:0] i_sum;
    logic [7:0] i_dc;
    logic       s_ov, s_co, s_gd;
    logic [3:0] s_sum;
    logic [1:0] s_dc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_delay_pipe #(.WIDTH(4), .LATENCY(3), .MODE(0), .CNT_W(8)) u_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
        .out_valid(t_ov), .sum(t_sum), .co(t_co), .glitch_drop(t_gd), .drop_count(t_dc));

    adder_delay_pipe #(.WIDTH(4), .LATENCY(3), .MODE(1), .CNT_W(8)) u_i (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
        .out_valid(i_ov), .sum(i_sum), .co(i_co), .glitch_drop(i_gd), .drop_count(i_dc));

    adder_delay_pipe #(.WIDTH(4), .LATENCY(3), .MODE(1), .CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
        .out_valid(s_ov), .sum(s_sum), .co(s_co), .glitch_drop(s_gd), .drop_count(s_dc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge: start of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
        in_valid = v;
        a = av;
        b = bv;
        ci = cv;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_t_ov", 32'(t_ov), 32'd0);
        chk("rst_t_sum", 32'({t_co, t_sum}), 32'd0);
        chk("rst_i_ov", 32'(i_ov), 32'd0);
        chk("rst_i_gd", 32'(i_gd), 32'd0);
        chk("rst_i_dc", 32'(i_dc), 32'd0);

        // Transport single: 5+3+1 = 9 in cycle 3
        drive(1'b1, 4'd5, 4'd3, 1'b1);
        tick(); drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("tr1_c1_ov", 32'(t_ov), 32'd0);
        tick();
        chk("tr1_c2_ov", 32'(t_ov), 32'd0);
        tick();
        chk("tr1_c3_ov", 32'(t_ov), 32'd1);
        chk("tr1_c3_res", 32'({t_co, t_sum}), 32'h09);
        tick();
        chk("tr1_c4_ov", 32'(t_ov), 32'd0);
        chk("tr1_c4_hold", 32'({t_co, t_sum}), 32'h09);
        chk("tr1_gd", 32'(t_gd), 32'd0);

        // Transport back-to-back
        do_reset();
        drive(1'b1, 4'hF, 4'h1, 1'b0);
        tick(); drive(1'b1, 4'h7, 4'h7, 1'b1);
        tick(); drive(1'b1, 4'h0, 4'h0, 1'b0);
        tick(); drive(1'b0, 4'h0, 4'h0, 1'b0);
        chk("b2b_c3_ov", 32'(t_ov), 32'd1);
        chk("b2b_c3_res", 32'({t_co, t_sum}), 32'h10);
        tick();
        chk("b2b_c4_ov", 32'(t_ov), 32'd1);
        chk("b2b_c4_res", 32'({t_co, t_sum}), 32'h0F);
        tick();
        chk("b2b_c5_ov", 32'(t_ov), 32'd1);
        chk("b2b_c5_res", 32'({t_co, t_sum}), 32'h00);
        tick();
        chk("b2b_c6_ov", 32'(t_ov), 32'd0);
        chk("b2b_dc", 32'(t_dc), 32'd0);

        // Inertial restart: 2+2 dropped, 9+9 commits in cycle 4
        do_reset();
        drive(1'b1, 4'd2, 4'd2, 1'b0);
        tick(); drive(1'b1, 4'd9, 4'd9, 1'b0);
        chk("rs_c1_gd", 32'(i_gd), 32'd0);
        tick(); drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("rs_c2_gd", 32'(i_gd), 32'd1);
        chk("rs_c2_dc", 32'(i_dc), 32'd1);
        chk("rs_c2_ov", 32'(i_ov), 32'd0);
        tick();
        chk("rs_c3_ov", 32'(i_ov), 32'd0);
        chk("rs_c3_gd", 32'(i_gd), 32'd0);
        tick();
        chk("rs_c4_ov", 32'(i_ov), 32'd1);
        chk("rs_c4_res", 32'({i_co, i_sum}), 32'h12);
        tick();
        chk("rs_c5_ov", 32'(i_ov), 32'd0);
        chk("rs_c5_dc", 32'(i_dc), 32'd1);

        // Inertial hold: 3+4 held cycles 0..8, one pulse in cycle 3
        do_reset();
        drive(1'b1, 4'd3, 4'd4, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 9) drive(1'b0, 4'd0, 4'd0, 1'b0);
            chk($sformatf("hold_c%0d_ov", k), 32'(i_ov), (k == 3) ? 32'd1 : 32'd0);
            if (k == 3) chk("hold_c3_res", 32'({i_co, i_sum}), 32'h07);
        end
        chk("hold_dc", 32'(i_dc), 32'd0);

        // Reset mid-flight, both modes
        do_reset();
        drive(1'b1, 4'd1, 4'd1, 1'b0);
        tick(); drive(1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b1;
        chk("mr_c1_t_ov", 32'(t_ov), 32'd0);
        chk("mr_c1_i_ov", 32'(i_ov), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            chk($sformatf("mr_c%0d_t_ov", k), 32'(t_ov), 32'd0);
            chk($sformatf("mr_c%0d_i_ov", k), 32'(i_ov), 32'd0);
            tick();
        end
        chk("mr_t_res", 32'({t_co, t_sum}), 32'd0);
        chk("mr_i_res", 32'({i_co, i_sum}), 32'd0);
        chk("mr_i_dc", 32'(i_dc), 32'd0);

        // Saturation with CNT_W=2: alternate 1+0+0 / 2+0+0 for 6 cycles
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            drive(1'b1, (k % 2 == 0) ? 4'd1 : 4'd2, 4'd0, 1'b0);
            if (k >= 2) begin
                chk($sformatf("sat_c%0d_gd", k), 32'(s_gd), 32'd1);
                chk($sformatf("sat_c%0d_dc", k), 32'(s_dc), (k - 1 > 3) ? 32'd3 : 32'(k - 1));
            end
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        chk("sat_c6_gd", 32'(s_gd), 32'd1);
        chk("sat_c6_dc", 32'(s_dc), 32'd3);
        tick();
        chk("sat_c7_gd", 32'(s_gd), 32'd0);
        chk("sat_c7_ov", 32'(s_ov), 32'd0);
        tick();
        chk("sat_c8_ov", 32'(s_ov), 32'd1);
        chk("sat_c8_res", 32'({s_co, s_sum}), 32'h02);
        chk("sat_c8_dc", 32'(s_dc), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
